// File: rtl/unit_sched_pkg.sv
// Shared definitions for the unit scheduler: FSM encoding, the index-width
// macro used on the port lists, and a counter-width helper.
`ifndef UNIT_SCHED_PKG_MSB_DEFINED
`define UNIT_SCHED_PKG_MSB_DEFINED
// Bit index of the most significant set bit of x (0 for x <= 1).
`define MSB(x) (((x) <= 1) ? 0 : ($clog2((x) + 1) - 1))
`endif

package unit_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_GRANT  = 2'd2
   } sched_state_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/unit_credit_cnt.sv
// Saturating per-unit in-flight counter; flags an increment at the ceiling or
// a decrement at zero and leaves the count untouched in that case.
module unit_credit_cnt #(
   parameter int MAX_CNT = 2,
   parameter int CW      = 2
) (
   input  logic          i_clk,
   input  logic          i_srst,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [CW-1:0] o_count,
   output logic          o_err
);

   logic [CW-1:0] r_count;
   logic          w_at_max;
   logic          w_at_zero;

   assign w_at_max  = (r_count == CW'(MAX_CNT));
   assign w_at_zero = (r_count == '0);

   // Simultaneous inc and dec cancel out and are never an error.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_count <= '0;
      end else if (i_inc && !i_dec && !w_at_max) begin
         r_count <= r_count + CW'(1);
      end else if (i_dec && !i_inc && !w_at_zero) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_count = r_count;
   assign o_err   = (i_dec && !i_inc && w_at_zero) || (i_inc && !i_dec && w_at_max);

endmodule

// File: rtl/unit_sched.sv
// Round-robin scheduler handing one candidate packet at a time to a compute
// unit, while tracking per-unit in-flight credits returned by results.
module unit_sched
   import unit_sched_pkg::*;
#(
   parameter int N_UNITS         = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                       CLK,
   input  logic                                       RST,
   input  logic                                       req,
   input  logic [N_UNITS-1:0]                         unit_ready,
   input  logic [N_UNITS-1:0]                         unit_tx_mask,
   output logic                                       grant,
   output logic [`MSB(N_UNITS-1):0]                   grant_unit,
   input  logic                                       tx_done,
   input  logic                                       rx_valid,
   input  logic [`MSB(N_UNITS-1):0]                   rx_unit,
   output logic [`MSB(N_UNITS*MAX_OUTSTANDING):0]     total_outstanding,
   output logic                                       idle,
   output logic                                       err
);

   localparam int UW = `MSB(N_UNITS-1) + 1;
   localparam int TW = `MSB(N_UNITS*MAX_OUTSTANDING) + 1;
   localparam int CW = cnt_width(MAX_OUTSTANDING);

   sched_state_e     r_state, w_state_next;
   logic [UW-1:0]    r_ptr, w_ptr_next;
   logic [UW-1:0]    r_grant_unit, w_grant_unit_next;
   logic [N_UNITS-1:0] r_ready, r_mask;
   logic [TW-1:0]    r_total, w_total_next;
   logic             r_idle;
   logic             r_err, w_err_next;

   logic [CW-1:0]    w_cnt [N_UNITS];
   logic [N_UNITS-1:0] w_inc, w_dec, w_cnt_err, w_up, w_dn, w_elig;
   logic             w_tx_fire;
   logic             w_rx_bad;
   logic             w_elig_ptr;

   function automatic logic [UW-1:0] ptr_wrap(input logic [UW-1:0] p);
      return (p == UW'(N_UNITS - 1)) ? '0 : p + UW'(1);
   endfunction

   assign w_tx_fire = tx_done && (r_state == ST_GRANT);
   assign w_rx_bad  = rx_valid && (32'(rx_unit) >= N_UNITS);

   genvar gi;
   generate
      for (gi = 0; gi < N_UNITS; gi++) begin : g_unit
         assign w_inc[gi] = w_tx_fire && (r_grant_unit == UW'(gi));
         assign w_dec[gi] = rx_valid && (rx_unit == UW'(gi));

         unit_credit_cnt #(
            .MAX_CNT (MAX_OUTSTANDING),
            .CW      (CW)
         ) u_cnt (
            .i_clk   (CLK),
            .i_srst  (RST),
            .i_inc   (w_inc[gi]),
            .i_dec   (w_dec[gi]),
            .o_count (w_cnt[gi]),
            .o_err   (w_cnt_err[gi])
         );

         assign w_elig[gi] = r_ready[gi] && !r_mask[gi] && (w_cnt[gi] < CW'(MAX_OUTSTANDING));
         // Net movement per unit, mirrored into the running total.
         assign w_up[gi]   = w_inc[gi] && !w_dec[gi] && !w_cnt_err[gi];
         assign w_dn[gi]   = w_dec[gi] && !w_inc[gi] && !w_cnt_err[gi];
      end
   endgenerate

   always_comb begin
      w_elig_ptr = 1'b0;
      for (int u = 0; u < N_UNITS; u++) begin
         if (r_ptr == UW'(u)) w_elig_ptr = w_elig[u];
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_ptr_next        = r_ptr;
      w_grant_unit_next = r_grant_unit;
      case (r_state)
         ST_IDLE: begin
            if (req) w_state_next = ST_SEARCH;
         end
         ST_SEARCH: begin
            if (!req) begin
               w_state_next = ST_IDLE;
            end else if (w_elig_ptr) begin
               w_grant_unit_next = r_ptr;
               w_state_next      = ST_GRANT;
            end else begin
               w_ptr_next = ptr_wrap(r_ptr);
            end
         end
         ST_GRANT: begin
            if (tx_done) begin
               w_ptr_next   = ptr_wrap(r_grant_unit);
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_total_next = r_total;
      if ((|w_up) && !(|w_dn)) begin
         w_total_next = r_total + TW'(1);
      end else if ((|w_dn) && !(|w_up)) begin
         w_total_next = r_total - TW'(1);
      end
      w_err_next = r_err || (tx_done && (r_state != ST_GRANT)) || w_rx_bad || (|w_cnt_err);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_grant_unit <= '0;
         r_ready      <= '0;
         r_mask       <= '0;
         r_total      <= '0;
         r_idle       <= 1'b1;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ptr        <= w_ptr_next;
         r_grant_unit <= w_grant_unit_next;
         r_ready      <= unit_ready;
         r_mask       <= unit_tx_mask;
         r_total      <= w_total_next;
         r_idle       <= (w_state_next == ST_IDLE) && (w_total_next == '0);
         r_err        <= w_err_next;
      end
   end

   assign grant             = (r_state == ST_GRANT);
   assign grant_unit        = r_grant_unit;
   assign total_outstanding = r_total;
   assign idle              = r_idle;
   assign err               = r_err;

endmodule

// File: tb/tb_unit_sched.sv
// Directed bench for unit_sched: a 4-unit and a 1-unit instance driven with
// hand-computed grant sequences, latencies, credit totals and error cases.
module tb_unit_sched;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 4-unit instance (MAX_OUTSTANDING = 2)
   logic       rst4, req4, tx4, rx4;
   logic [3:0] ready4, mask4;
   logic [1:0] rxu4, gu4;
   logic       grant4, idle4, err4;
   logic [3:0] tot4;

   // 1-unit instance (MAX_OUTSTANDING = 2)
   logic       rst1, req1, tx1, rx1;
   logic [0:0] ready1, mask1, rxu1, gu1;
   logic       grant1, idle1, err1;
   logic [1:0] tot1;

   int n_checks = 0;
   int n_errors = 0;

   unit_sched #(.N_UNITS(4), .MAX_OUTSTANDING(2)) dut4 (
      .CLK(clk), .RST(rst4), .req(req4), .unit_ready(ready4), .unit_tx_mask(mask4),
      .grant(grant4), .grant_unit(gu4), .tx_done(tx4), .rx_valid(rx4), .rx_unit(rxu4),
      .total_outstanding(tot4), .idle(idle4), .err(err4)
   );

   unit_sched #(.N_UNITS(1), .MAX_OUTSTANDING(2)) dut1 (
      .CLK(clk), .RST(rst1), .req(req1), .unit_ready(ready1), .unit_tx_mask(mask1),
      .grant(grant1), .grant_unit(gu1), .tx_done(tx1), .rx_valid(rx1), .rx_unit(rxu1),
      .total_outstanding(tot1), .idle(idle1), .err(err1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic reset4();
      rst4 = 1'b1; req4 = 1'b0; tx4 = 1'b0; rx4 = 1'b0; rxu4 = '0;
      tick(); tick();
      rst4 = 1'b0;
   endtask

   // Raise req and count cycles until grant shows (bounded).
   task automatic await_grant4(input string tag, input int exp_unit, input int exp_lat);
      int lat;
      lat = 0;
      req4 = 1'b1;
      do begin
         tick();
         lat++;
      end while (!grant4 && lat < 20);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_unit"}, gu4, exp_unit);
   endtask

   task automatic txn4(input string tag, input int exp_unit, input int exp_lat, input bit drop);
      await_grant4(tag, exp_unit, exp_lat);
      tx4 = 1'b1;
      if (drop) req4 = 1'b0;
      tick();
      tx4 = 1'b0;
      check({tag, "_fall"}, grant4, 0);
   endtask

   task automatic txn1(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      req1 = 1'b1;
      do begin
         tick();
         lat++;
      end while (!grant1 && lat < 20);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_unit"}, gu1, 0);
      tx1 = 1'b1; req1 = 1'b0;
      tick();
      tx1 = 1'b0;
   endtask

   initial begin
      int lat;
      rst4 = 1'b1; req4 = 0; tx4 = 0; rx4 = 0; rxu4 = '0; ready4 = '0; mask4 = '0;
      rst1 = 1'b1; req1 = 0; tx1 = 0; rx1 = 0; rxu1 = '0; ready1 = '0; mask1 = '0;
      tick(); tick();
      rst4 = 1'b0; rst1 = 1'b0;

      // Reset state
      check("rst_grant", grant4, 0);
      check("rst_gunit", gu4, 0);
      check("rst_total", tot4, 0);
      check("rst_err", err4, 0);
      check("rst_idle", idle4, 1);
      check("rst1_idle", idle1, 1);

      // Round robin, all ready, req held
      ready4 = 4'hF; mask4 = 4'h0;
      tick();
      txn4("rr0", 0, 2, 0);
      txn4("rr1", 1, 2, 0);
      txn4("rr2", 2, 2, 0);
      txn4("rr3", 3, 2, 0);
      check("rr_total4", tot4, 4);
      txn4("rr4", 0, 2, 1);
      check("rr_total5", tot4, 5);
      tick();
      check("rr_idle_busy", idle4, 0);
      check("rr_err", err4, 0);

      // Mask and not-ready skipping
      reset4();
      ready4 = 4'b1011; mask4 = 4'b0010;
      tick();
      txn4("sk0", 0, 2, 1);
      txn4("sk3", 3, 4, 1);
      txn4("sk0b", 0, 2, 1);
      check("sk_total", tot4, 3);

      // Reset while granting with 3 outstanding; tx/rx in reset cycle ignored
      await_grant4("rg", 3, 4);
      check("rg_grant", grant4, 1);
      check("rg_total", tot4, 3);
      rst4 = 1'b1; tx4 = 1'b1; rx4 = 1'b1; rxu4 = 2'd0;
      tick();
      check("rg_grant_after", grant4, 0);
      check("rg_total_after", tot4, 0);
      check("rg_err_after", err4, 0);
      check("rg_idle_after", idle4, 1);
      rst4 = 1'b0; tx4 = 1'b0; rx4 = 1'b0; req4 = 1'b0;

      // Same-cycle tx_done/rx_valid on unit 0, then rx errors
      reset4();
      ready4 = 4'hF; mask4 = 4'h0;
      tick();
      await_grant4("sc", 0, 2);
      tx4 = 1'b1; rx4 = 1'b1; rxu4 = 2'd0; req4 = 1'b0;
      tick();
      tx4 = 1'b0; rx4 = 1'b0;
      check("sc_total", tot4, 0);
      check("sc_err", err4, 0);
      rx4 = 1'b1; rxu4 = 2'd1;
      tick();
      rx4 = 1'b0;
      check("rxz_err", err4, 1);
      check("rxz_total", tot4, 0);
      tick(); tick();
      check("rxz_sticky", err4, 1);
      rx4 = 1'b1; rxu4 = 2'd0;
      tick();
      rx4 = 1'b0;
      check("rxz0_total", tot4, 0);
      tick();
      check("rxz0_idle", idle4, 1);
      // tx_done outside GRANT is an error (already sticky here, count must not move)
      tx4 = 1'b1;
      tick();
      tx4 = 1'b0;
      check("txidle_total", tot4, 0);

      // Single unit, credit limit
      ready1 = 1'b1; mask1 = 1'b0;
      tick();
      txn1("s1a", 2);
      txn1("s1b", 2);
      check("s1_total2", tot1, 2);
      req1 = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("s1_blocked", grant1, 0);
      check("s1_idle", idle1, 0);
      rx1 = 1'b1; rxu1 = 1'b0;
      tick();
      rx1 = 1'b0;
      check("s1_total1", tot1, 1);
      lat = 1;
      while (!grant1 && lat < 20) begin
         tick();
         lat++;
      end
      check("s1_lat_le2", (lat <= 2) ? 1 : 0, 1);
      check("s1_grant", grant1, 1);
      tx1 = 1'b1; req1 = 1'b0;
      tick();
      tx1 = 1'b0;
      check("s1_total_back", tot1, 2);
      check("s1_err", err1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
